apb_mem_responder: RTL and testbench
====================================

// Module: apb_mem_responder
// PURPOSE
//   Memory-side responder for the control unit's instruction and data fetch requests.
//   Owns one DEPTH x 16 single-port array shared by an instruction channel (read-only)
//   and a data channel (read/write), with configurable wait states.
//   Serves one access at a time, arbitrates round-robin and returns a one-cycle READY_*
//   pulse per request. Sits between the control/datapath and the program/data store.
// PARAMETERS
//   ADDR_W       11     address width; DEPTH = 2**ADDR_W words, so no address is out of range
//   DATA_W       16     word width
//   WAIT_CYCLES  1      wait states inserted before READY; legal range 0..15
// PORTS
//   CLK          in   1       clock; all logic on the rising edge
//   RESET        in   1       synchronous, active-high reset
//   EN_INST      in   1       instruction read request (level)
//   INST_ADDR    in   ADDR_W  instruction address (PC)
//   READY_INST   out  1       one-cycle pulse: INST_RDATA valid
//   INST_RDATA   out  DATA_W  instruction word
//   EN_DATA      in   1       data access request (level)
//   WRITE        in   1       1 = data write, 0 = data read; sampled with EN_DATA
//   DATA_ADDR    in   ADDR_W  data address (OPERAND)
//   DATA_WDATA   in   DATA_W  write data (ACC)
//   READY_DATA   out  1       one-cycle pulse: read data valid or write committed
//   DATA_RDATA   out  DATA_W  data read word
//   BUSY         out  1       high in every state except IDLE
// BEHAVIOUR
//   Reset: READY_INST=0, READY_DATA=0, INST_RDATA=0, DATA_RDATA=0, BUSY=0, state=IDLE,
//     arm_i=arm_d=0, last=INST, wait counter=0. Array contents are not cleared.
//   Arming: arm_x sets in any cycle where EN_x=0. A channel requests when EN_x=1 and arm_x=1.
//     Acceptance clears arm_x. A held EN therefore yields exactly one response. EN must drop
//     for at least one cycle before the next request on that channel.
//   States: IDLE -> WAIT -> RESP -> IDLE. With WAIT_CYCLES=0, IDLE -> RESP directly.
//   IDLE: if any channel requests, grant it and latch ADDR, WRITE and WDATA.
//     If both request, grant the channel not equal to 'last'; the first tie after reset goes to DATA.
//     Load cnt=WAIT_CYCLES-1 and go to WAIT, or go to RESP if WAIT_CYCLES=0.
//   WAIT: decrement cnt; go to RESP when cnt==0. Requests stay pending and are not sampled.
//   RESP: pulse READY of the granted channel for exactly one cycle. Set last=granted, then go to IDLE.
//     Read: RDATA register loads mem[latched addr] on the edge entering RESP, so it is valid with READY.
//     Write: mem[latched addr] <= latched WDATA on the edge leaving RESP.
//   Latency: acceptance at edge N; READY high in the cycle after edge N+1+WAIT_CYCLES.
//     Minimum spacing between back-to-back accesses is WAIT_CYCLES+2 cycles.
//   RDATA outputs hold their last value until the next read response on the same channel.
//     Writes never change DATA_RDATA.
//   Input changes after acceptance (ADDR, WRITE, WDATA, EN) do not affect the access in flight.
//   EN dropping mid-access does not cancel it; READY still pulses.
//   Read and write to the same address in consecutive accesses: the read returns the new value.
//   Reset mid-access: return to IDLE with no READY pulse. A pending write is discarded,
//     and the array is left unchanged for that access.
//   Never assert READY_INST and READY_DATA in the same cycle.
// TESTING
//   1) WAIT_CYCLES=1: preload mem[0x005]=0xA5C3; EN_INST=1 with INST_ADDR=0x005 held
//      -> one READY_INST pulse 2 cycles after acceptance, INST_RDATA=0xA5C3, no second pulse.
//   2) Data write 0x1234 to 0x7FF (WRITE=1), drop EN, then read 0x7FF
//      -> READY_DATA on both accesses; the read returns DATA_RDATA=0x1234.
//   3) EN_INST and EN_DATA rise in the same cycle after reset -> DATA is served first, then INST.
//      Repeat both -> INST is served first; READY pulses never overlap.
//   4) WAIT_CYCLES=0 and WAIT_CYCLES=15 -> READY appears 1 and 16 cycles after acceptance
//      respectively; BUSY is high throughout each access.
//   5) RESET asserted in WAIT during a write of 0xBEEF to 0x010 (previously 0x0000)
//      -> no READY; mem[0x010] stays 0x0000; a held EN is not served until it drops and re-rises.
//   6) Change DATA_ADDR and DATA_WDATA one cycle after acceptance -> the write lands at the
//      originally latched address with the originally latched data.

Source files
------------

// File: rtl/apb_mem_responder.sv
// Single-port DEPTH x DATA_W memory responder serving an instruction read channel and a
// data read/write channel, one access at a time, round-robin arbitrated, with wait states.
module apb_mem_responder #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN_INST,
  input  logic [ADDR_W-1:0] INST_ADDR,
  output logic              READY_INST,
  output logic [DATA_W-1:0] INST_RDATA,
  input  logic              EN_DATA,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] DATA_ADDR,
  input  logic [DATA_W-1:0] DATA_WDATA,
  output logic              READY_DATA,
  output logic [DATA_W-1:0] DATA_RDATA,
  output logic              BUSY
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    CH_INST = 1'b0,
    CH_DATA = 1'b1
  } ch_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic              accept_s;

  logic              arm_inst_r;
  logic              arm_data_r;
  logic              req_inst_s;
  logic              req_data_s;
  ch_t               sel_ch_s;
  ch_t               last_r;

  ch_t               gnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              write_r;
  logic [DATA_W-1:0] wdata_r;

  ch_t               acc_ch_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic              acc_write_s;
  logic              load_rdata_s;
  logic              commit_s;

  logic              ready_inst_r;
  logic              ready_data_r;
  logic              busy_r;
  logic [DATA_W-1:0] inst_rdata_r;
  logic [DATA_W-1:0] data_rdata_r;

  assign READY_INST = ready_inst_r;
  assign READY_DATA = ready_data_r;
  assign INST_RDATA = inst_rdata_r;
  assign DATA_RDATA = data_rdata_r;
  assign BUSY       = busy_r;

  // Request qualification and round-robin pick; a tie goes to the channel not served last
  always_comb begin
    req_inst_s = EN_INST & arm_inst_r;
    req_data_s = EN_DATA & arm_data_r;
    if (req_inst_s && req_data_s) begin
      sel_ch_s = (last_r == CH_INST) ? CH_DATA : CH_INST;
    end else if (req_data_s) begin
      sel_ch_s = CH_DATA;
    end else begin
      sel_ch_s = CH_INST;
    end
  end

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_inst_s || req_data_s) begin
          accept_s    = 1'b1;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = HAS_WAIT ? ST_WAIT : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Access attributes: live inputs on the accepting edge, latched copies afterwards.
  // With no wait states the array read happens on the same edge as acceptance.
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_ch_s    = sel_ch_s;
      acc_addr_s  = (sel_ch_s == CH_DATA) ? DATA_ADDR : INST_ADDR;
      acc_write_s = (sel_ch_s == CH_DATA) && WRITE;
    end else begin
      acc_ch_s    = gnt_r;
      acc_addr_s  = addr_r;
      acc_write_s = write_r;
    end
    load_rdata_s = (state_nxt_s == ST_RESP) && !acc_write_s;
    commit_s     = (state_r == ST_RESP) && write_r;
  end

  // State and wait counter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Arming: a channel must see EN low once before each new request is honoured
  always_ff @(posedge CLK) begin
    if (RESET) begin
      arm_inst_r <= 1'b0;
      arm_data_r <= 1'b0;
    end else begin
      if (!EN_INST) begin
        arm_inst_r <= 1'b1;
      end else if (accept_s && (sel_ch_s == CH_INST)) begin
        arm_inst_r <= 1'b0;
      end else begin
        arm_inst_r <= arm_inst_r;
      end
      if (!EN_DATA) begin
        arm_data_r <= 1'b1;
      end else if (accept_s && (sel_ch_s == CH_DATA)) begin
        arm_data_r <= 1'b0;
      end else begin
        arm_data_r <= arm_data_r;
      end
    end
  end

  // Capture the granted request so later input changes cannot disturb it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_r   <= CH_INST;
      addr_r  <= '0;
      write_r <= 1'b0;
      wdata_r <= '0;
      last_r  <= CH_INST;
    end else begin
      if (accept_s) begin
        gnt_r   <= acc_ch_s;
        addr_r  <= acc_addr_s;
        write_r <= acc_write_s;
        wdata_r <= DATA_WDATA;
      end
      if (state_r == ST_RESP) begin
        last_r <= gnt_r;
      end
    end
  end

  // Registered responses; READY rises on the edge leaving RESP, read data one edge earlier
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ready_inst_r <= 1'b0;
      ready_data_r <= 1'b0;
      busy_r       <= 1'b0;
      inst_rdata_r <= '0;
      data_rdata_r <= '0;
    end else begin
      ready_inst_r <= (state_r == ST_RESP) && (gnt_r == CH_INST);
      ready_data_r <= (state_r == ST_RESP) && (gnt_r == CH_DATA);
      busy_r       <= (state_nxt_s != ST_IDLE);
      if (load_rdata_s && (acc_ch_s == CH_INST)) begin
        inst_rdata_r <= mem[acc_addr_s];
      end
      if (load_rdata_s && (acc_ch_s == CH_DATA)) begin
        data_rdata_r <= mem[acc_addr_s];
      end
    end
  end

  // Array write; a reset on the committing edge discards the write
  always_ff @(posedge CLK) begin
    if (commit_s && !RESET) begin
      mem[addr_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Scoreboard bench for apb_mem_responder: WAIT_CYCLES=1 main instance plus
// WAIT_CYCLES=0 and WAIT_CYCLES=15 instances sharing inputs for latency checks.
module tb_apb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_inst;
  logic [10:0] inst_addr;
  logic        en_data;
  logic        wr;
  logic [10:0] data_addr;
  logic [15:0] wdata;

  // index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=1 (main), index 2: WAIT_CYCLES=15
  logic        rdy_i  [3];
  logic        rdy_d  [3];
  logic [15:0] irdata [3];
  logic [15:0] drdata [3];
  logic        busy   [3];

  always #5 clk = ~clk;

  apb_mem_responder #(.ADDR_W(11), .DATA_W(16), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(clk), .RESET(rst), .EN_INST(en_inst), .INST_ADDR(inst_addr),
    .READY_INST(rdy_i[0]), .INST_RDATA(irdata[0]), .EN_DATA(en_data), .WRITE(wr),
    .DATA_ADDR(data_addr), .DATA_WDATA(wdata), .READY_DATA(rdy_d[0]),
    .DATA_RDATA(drdata[0]), .BUSY(busy[0]));

  apb_mem_responder #(.ADDR_W(11), .DATA_W(16), .WAIT_CYCLES(1)) dut (
    .CLK(clk), .RESET(rst), .EN_INST(en_inst), .INST_ADDR(inst_addr),
    .READY_INST(rdy_i[1]), .INST_RDATA(irdata[1]), .EN_DATA(en_data), .WRITE(wr),
    .DATA_ADDR(data_addr), .DATA_WDATA(wdata), .READY_DATA(rdy_d[1]),
    .DATA_RDATA(drdata[1]), .BUSY(busy[1]));

  apb_mem_responder #(.ADDR_W(11), .DATA_W(16), .WAIT_CYCLES(15)) dut_w15 (
    .CLK(clk), .RESET(rst), .EN_INST(en_inst), .INST_ADDR(inst_addr),
    .READY_INST(rdy_i[2]), .INST_RDATA(irdata[2]), .EN_DATA(en_data), .WRITE(wr),
    .DATA_ADDR(data_addr), .DATA_WDATA(wdata), .READY_DATA(rdy_d[2]),
    .DATA_RDATA(drdata[2]), .BUSY(busy[2]));

  typedef struct {
    bit          is_data;
    bit          is_write;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] model [2048];
  logic [15:0] data_rd_exp;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_data, input bit is_write, input logic [10:0] addr,
                          input logic [15:0] wd);
    exp_t x;
    if (is_write) model[addr] = wd;
    x.is_data  = is_data;
    x.is_write = is_write;
    x.val      = is_write ? 16'h0000 : model[addr];
    exp_q.push_back(x);
  endtask

  // Scoreboard consumer for the main instance
  always @(negedge clk) begin
    if (rdy_i[1] || rdy_d[1]) begin
      if (rdy_i[1] && rdy_d[1]) begin
        check_eq("ready_overlap", 1, 0);
      end else if (exp_q.size() == 0) begin
        check_eq("unexpected_ready", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("channel_order", int'(rdy_d[1]), int'(e.is_data));
        if (!e.is_data) begin
          check_eq("inst_rdata", int'(irdata[1]), int'(e.val));
        end else if (e.is_write) begin
          check_eq("write_keeps_rdata", int'(drdata[1]), int'(data_rd_exp));
        end else begin
          check_eq("data_rdata", int'(drdata[1]), int'(e.val));
          data_rd_exp = e.val;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en_inst = 1'b0;
    en_data = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    data_rd_exp = 16'h0000;
  endtask

  // One access on the main instance; latency counted in negedges after the drive
  task automatic access(input bit is_data, input bit is_write, input logic [10:0] addr,
                        input logic [15:0] wd, input int hold, input bit perturb);
    int lat;
    @(negedge clk);
    if (is_data) begin
      en_data = 1'b1; wr = is_write; data_addr = addr; wdata = wd;
    end else begin
      en_inst = 1'b1; inst_addr = addr;
    end
    push_exp(is_data, is_write, addr, wd);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (perturb && i == 1) begin
        data_addr = addr ^ 11'h001; wdata = ~wd; wr = ~is_write;
      end
      if (is_data ? rdy_d[1] : rdy_i[1]) lat = i;
      else check_eq("busy_in_access", int'(busy[1]), 1);
    end
    check_eq(is_data ? "lat_data" : "lat_inst", lat, 3);
    repeat (hold) @(negedge clk);
    en_data = 1'b0;
    en_inst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat0, lat15, p0, p15;
    rst = 1'b1; en_inst = 1'b0; en_data = 1'b0; wr = 1'b0;
    inst_addr = 11'h000; data_addr = 11'h000; wdata = 16'h0000;
    data_rd_exp = 16'h0000;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ready_inst", int'(rdy_i[k]), 0);
      check_eq("rst_ready_data", int'(rdy_d[k]), 0);
      check_eq("rst_inst_rdata", int'(irdata[k]), 0);
      check_eq("rst_data_rdata", int'(drdata[k]), 0);
      check_eq("rst_busy", int'(busy[k]), 0);
    end
    rst = 1'b0;

    // Tie after reset goes to DATA; a second tie with last=DATA goes to INST
    @(negedge clk);
    data_addr = 11'h030; wdata = 16'h1111; wr = 1'b1; inst_addr = 11'h030;
    en_inst = 1'b1; en_data = 1'b1;
    push_exp(1'b1, 1'b1, 11'h030, 16'h1111);
    push_exp(1'b0, 1'b0, 11'h030, 16'h0000);
    push_exp(1'b1, 1'b1, 11'h030, 16'h1111);
    @(negedge clk);
    en_inst = 1'b0; en_data = 1'b0;
    @(negedge clk);
    en_inst = 1'b1; en_data = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("tie_drained", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    en_inst = 1'b0; en_data = 1'b0;

    // Preload then held instruction read: exactly one pulse
    access(1'b1, 1'b1, 11'h005, 16'hA5C3, 0, 1'b0);
    access(1'b0, 1'b0, 11'h005, 16'h0000, 6, 1'b0);

    // Write/read at the top address
    access(1'b1, 1'b1, 11'h7FF, 16'h1234, 0, 1'b0);
    access(1'b1, 1'b0, 11'h7FF, 16'h0000, 0, 1'b0);

    // Inputs changed after acceptance do not affect the write
    access(1'b1, 1'b1, 11'h021, 16'h0000, 0, 1'b0);
    access(1'b1, 1'b1, 11'h020, 16'h5A5A, 0, 1'b1);
    access(1'b1, 1'b0, 11'h020, 16'h0000, 0, 1'b0);
    access(1'b1, 1'b0, 11'h021, 16'h0000, 0, 1'b0);

    // Reset while in WAIT during a write: no READY, array unchanged, held EN ignored
    access(1'b1, 1'b1, 11'h010, 16'h0000, 0, 1'b0);
    @(negedge clk);
    en_data = 1'b1; wr = 1'b1; data_addr = 11'h010; wdata = 16'hBEEF;
    @(negedge clk);
    check_eq("busy_before_reset", int'(busy[1]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_rd_exp = 16'h0000;
    check_eq("no_ready_after_reset", int'(rdy_d[1]), 0);
    check_eq("idle_after_reset", int'(busy[1]), 0);
    repeat (6) @(negedge clk);
    check_eq("held_en_not_served", int'(busy[1]), 0);
    en_data = 1'b0;
    access(1'b1, 1'b0, 11'h010, 16'h0000, 0, 1'b0);

    // Latency extremes on the WAIT_CYCLES=0 and WAIT_CYCLES=15 instances
    do_reset();
    @(negedge clk);
    en_inst = 1'b1; inst_addr = 11'h005;
    push_exp(1'b0, 1'b0, 11'h005, 16'h0000);
    lat0 = 0; lat15 = 0; p0 = 0; p15 = 0;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (rdy_i[0]) begin p0++; if (lat0 == 0) lat0 = i; end
      else if (lat0 == 0) check_eq("busy_w0", int'(busy[0]), 1);
      if (rdy_i[2]) begin p15++; if (lat15 == 0) lat15 = i; end
      else if (lat15 == 0) check_eq("busy_w15", int'(busy[2]), 1);
    end
    check_eq("lat_w0", lat0, 2);
    check_eq("lat_w15", lat15, 17);
    check_eq("pulses_w0", p0, 1);
    check_eq("pulses_w15", p15, 1);
    en_inst = 1'b0;

    repeat (5) @(negedge clk);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
